// File: rtl/adc_capture_multi.sv
// adc_capture_multi: multi-channel ADC snapshot engine.
// Captures a programmable number of (optionally decimated) beats per enabled
// channel after a trigger and writes them to per-channel buffer ports.
//
// Optional feature macro: ADC_CAPTURE_TIMESTAMP_EN
//   defined     -> free-running 32-bit cycle counter, latched into trig_time
//                  on the ARMED->CAPTURE transition
//   not defined -> trig_time tied to 0
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axis_tdata/tvalid  per-channel ADC beats (channel c at [c*W +: W])
//   s_axis_tready        per-channel ready, 1 whenever out of reset
//   arm, trig, abort     control: arm pulse, trigger level, abort pulse
//   chmask, decim, nsamp capture setup, sampled on arm
//   bram_addr/din/we     per-channel buffer write port (registered)
//   busy, done, done_pulse, trig_time  status
module adc_capture_multi #(
    parameter int unsigned NCH                = 4,
    parameter int unsigned ADC_AXIS_DATAWIDTH = 64,
    parameter int unsigned DEPTH_LOG2         = 12,
    parameter int unsigned DECIM_WIDTH        = 8
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NCH*ADC_AXIS_DATAWIDTH-1:0]   s_axis_tdata,
    input  logic [NCH-1:0]                      s_axis_tvalid,
    output logic [NCH-1:0]                      s_axis_tready,
    input  logic                                arm,
    input  logic                                trig,
    input  logic                                abort,
    input  logic [NCH-1:0]                      chmask,
    input  logic [DECIM_WIDTH-1:0]              decim,
    input  logic [DEPTH_LOG2:0]                 nsamp,
    output logic [NCH*DEPTH_LOG2-1:0]           bram_addr,
    output logic [NCH*ADC_AXIS_DATAWIDTH-1:0]   bram_din,
    output logic [NCH-1:0]                      bram_we,
    output logic                                busy,
    output logic                                done,
    output logic                                done_pulse,
    output logic [31:0]                         trig_time
);

    localparam int unsigned W     = ADC_AXIS_DATAWIDTH;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   latch_c;
    logic [NCH-1:0]         mask_q;
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [CW-1:0]          nsamp_q;
    logic [CW-1:0]          nsamp_clamp_c;
    logic [CW-1:0]          cnt_q  [NCH];
    logic [DECIM_WIDTH-1:0] dcnt_q [NCH];
    logic [NCH-1:0]         ch_done_c;
    logic [NCH-1:0]         beat_c;
    logic [NCH-1:0]         wr_c;
    logic                   all_done_c;

    // Per-channel completion, accepted beats and buffer writes
    always_comb begin
        nsamp_clamp_c = nsamp;
        ch_done_c     = '0;
        beat_c        = '0;
        wr_c          = '0;
        if ((nsamp == '0) || (nsamp > CW'(DEPTH))) begin
            nsamp_clamp_c = CW'(DEPTH);
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            // masked channels count as complete so they never hold off DONE
            ch_done_c[c] = !mask_q[c] || (cnt_q[c] == nsamp_q);
            beat_c[c]    = (state_q == ST_CAPTURE) && !abort && !ch_done_c[c]
                           && s_axis_tvalid[c];
            wr_c[c]      = beat_c[c] && (dcnt_q[c] == '0);
        end
        all_done_c = &ch_done_c;
    end

    // Next-state logic; abort overrides everything, arm in ARMED beats trig
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        latch_c = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (arm) begin
                        latch_c = 1'b1;
                    end else if (trig) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (all_done_c) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register and registered status outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            done_pulse    <= 1'b0;
            s_axis_tready <= '0;
        end else begin
            state_q       <= state_d;
            busy          <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            done          <= (state_d == ST_DONE);
            done_pulse    <= (state_d == ST_DONE) && (state_q != ST_DONE);
            s_axis_tready <= '1;
        end
    end

    // Capture setup latched on arm
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask_q  <= '0;
            decim_q <= '0;
            nsamp_q <= CW'(DEPTH);
        end else if (latch_c) begin
            mask_q  <= chmask;
            decim_q <= decim;
            nsamp_q <= nsamp_clamp_c;
        end
    end

    // Per-channel sample/decimation counters and buffer write port
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                cnt_q[c]  <= '0;
                dcnt_q[c] <= '0;
            end
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= wr_c;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (latch_c) begin
                    cnt_q[c]  <= '0;
                    dcnt_q[c] <= '0;
                end else if (beat_c[c]) begin
                    dcnt_q[c] <= (dcnt_q[c] == decim_q) ? '0
                                                        : dcnt_q[c] + DECIM_WIDTH'(1);
                    if (wr_c[c]) begin
                        cnt_q[c] <= cnt_q[c] + CW'(1);
                    end
                end
                if (wr_c[c]) begin
                    bram_addr[c*AW +: AW] <= cnt_q[c][AW-1:0];
                    bram_din[c*W +: W]    <= s_axis_tdata[c*W +: W];
                end
            end
        end
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle counter; snapshot taken on the trigger edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_q      <= '0;
            trig_time <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if ((state_q == ST_ARMED) && (state_d == ST_CAPTURE)) begin
                trig_time <= ts_q;
            end
        end
    end
`else
    assign trig_time = '0;
`endif

endmodule
